data_store_buffer: RTL

//  Posted-write buffer on the core's SRAM-like data port, between mips (upstream) and the SRAM-to-AXI bridge (downstream).

---
 rtl/data_store_buffer.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/data_store_buffer.sv
// Posted-write buffer between the core data port and the SRAM-to-AXI bridge.
// Latency: a store completes one cycle after acceptance; a load completes one cycle after the bridge's data_ok.
// Backpressure: cpu_addr_ok drops when the buffer is full, when a load meets a non-empty buffer, or while a load is in flight.
module data_store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_wr,
  input  logic [1:0]  cpu_size,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic        cpu_uncached,
  output logic [31:0] cpu_rdata,
  output logic        cpu_addr_ok,
  output logic        cpu_data_ok,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_uncached,
  input  logic [31:0] mem_rdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  output logic        sb_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {RD_IDLE, RD_REQ, RD_WAIT} rd_state_t;
  typedef enum logic [1:0] {D_IDLE, D_REQ, D_WAIT} dr_state_t;

  rd_state_t rd_st, rd_nxt;
  dr_state_t dr_st, dr_nxt;

  // Store entries; DEPTH is a power of two so the pointers wrap on their own.
  logic [31:0]   ent_addr  [DEPTH];
  logic [31:0]   ent_wdata [DEPTH];
  logic [1:0]    ent_size  [DEPTH];
  logic          ent_unc   [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  // Fields of the single outstanding load.
  logic [31:0] ld_addr;
  logic [1:0]  ld_size;
  logic        ld_unc;

  logic store_acc;
  logic load_acc;
  logic push;
  logic pop;
  logic rd_done;

  // The buffer is only "empty" once the last write has fully completed on the bridge.
  assign sb_empty    = (count == '0) && (dr_st == D_IDLE);
  assign store_acc   = cpu_req & cpu_wr & (count < FULL_CNT) & (rd_st == RD_IDLE);
  assign load_acc    = cpu_req & ~cpu_wr & sb_empty & (rd_st == RD_IDLE);
  assign cpu_addr_ok = store_acc | load_acc;
  assign push        = store_acc;
  assign pop         = (dr_st == D_WAIT) & mem_data_ok;
  assign rd_done     = (rd_st == RD_WAIT) & mem_data_ok;

  // Entry storage: only written on push, so it carries no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      ent_addr[wr_ptr]  <= cpu_addr;
      ent_wdata[wr_ptr] <= cpu_wdata;
      ent_size[wr_ptr]  <= cpu_size;
      ent_unc[wr_ptr]   <= cpu_uncached;
    end
  end

  // FIFO pointers and occupancy; a simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + (AW+1)'(1);
      else if (pop && !push) count <= count - (AW+1)'(1);
    end
  end

  // Latch the load request so it stays stable on the bridge until accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      ld_addr <= '0;
      ld_size <= '0;
      ld_unc  <= 1'b0;
    end else if (load_acc) begin
      ld_addr <= cpu_addr;
      ld_size <= cpu_size;
      ld_unc  <= cpu_uncached;
    end
  end

  // Read FSM state register.
  always_ff @(posedge clk) begin
    if (rst) rd_st <= RD_IDLE;
    else     rd_st <= rd_nxt;
  end

  // Read FSM next state: request, wait for acceptance, wait for data.
  always_comb begin
    rd_nxt = rd_st;
    case (rd_st)
      RD_IDLE: if (load_acc)    rd_nxt = RD_REQ;
      RD_REQ:  if (mem_addr_ok) rd_nxt = RD_WAIT;
      RD_WAIT: if (mem_data_ok) rd_nxt = RD_IDLE;
      default: rd_nxt = RD_IDLE;
    endcase
  end

  // Drain FSM state register.
  always_ff @(posedge clk) begin
    if (rst) dr_st <= D_IDLE;
    else     dr_st <= dr_nxt;
  end

  // Drain FSM next state: never starts while a load owns the bridge.
  always_comb begin
    dr_nxt = dr_st;
    case (dr_st)
      D_IDLE:  if ((count != '0) && (rd_st == RD_IDLE)) dr_nxt = D_REQ;
      D_REQ:   if (mem_addr_ok) dr_nxt = D_WAIT;
      D_WAIT:  if (mem_data_ok) dr_nxt = D_IDLE;
      default: dr_nxt = D_IDLE;
    endcase
  end

  // Core completions: stores ack the cycle after push, loads the cycle after bridge data.
  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_data_ok <= 1'b0;
      cpu_rdata   <= '0;
    end else begin
      cpu_data_ok <= push | rd_done;
      if (rd_done) cpu_rdata <= mem_rdata;
    end
  end

  // Bridge request mux; read and drain are mutually exclusive, all fields zero when idle.
  always_comb begin
    mem_req      = 1'b0;
    mem_wr       = 1'b0;
    mem_size     = '0;
    mem_addr     = '0;
    mem_wdata    = '0;
    mem_uncached = 1'b0;
    if (rd_st == RD_REQ) begin
      mem_req      = 1'b1;
      mem_size     = ld_size;
      mem_addr     = ld_addr;
      mem_uncached = ld_unc;
    end else if (dr_st == D_REQ) begin
      mem_req      = 1'b1;
      mem_wr       = 1'b1;
      mem_size     = ent_size[rd_ptr];
      mem_addr     = ent_addr[rd_ptr];
      mem_wdata    = ent_wdata[rd_ptr];
      mem_uncached = ent_unc[rd_ptr];
    end
  end

endmodule
